// File: rtl/miriscv_lsu.sv
// miriscv_lsu -- load/store unit between the core pipeline and a 32-bit
// request/grant/response data memory port.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   lsu_req_i             core requests a load/store (held while stalled)
//   lsu_we_i              1 = store, 0 = load
//   lsu_size_i[2:0]       funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU (others illegal)
//   lsu_addr_i[31:0]      byte address
//   lsu_data_i[31:0]      right-aligned store data
//   lsu_data_o[31:0]      formatted load result (0 for stores/illegal)
//   lsu_stall_req_o       pipeline freeze request
//   lsu_misalign_o        misaligned-access flag, one cycle in DONE
//   lsu_state_o[1:0]      debug view of the FSM (0 IDLE, 1 WAIT_GNT,
//                         2 WAIT_RVALID, 3 DONE)
//   data_req_o/we_o/be_o/addr_o/wdata_o   memory request channel
//   data_gnt_i            memory accepted the request
//   data_rvalid_i, data_rdata_i[31:0]     memory response
//
// Configuration
//   MIRISCV_LSU_MISALIGN_EXC_EN  when defined, misaligned half/word accesses
//   are not issued and raise lsu_misalign_o; when undefined the offending low
//   address bits are ignored and the access is issued.
//
// Handshake: data_req_o and its attributes stay stable from the first request
// cycle until the cycle data_gnt_i is seen high (request accepted on that
// edge). Exactly one data_rvalid_i is then expected; it is only honoured in
// WAIT_RVALID and ignored in every other state.
module miriscv_lsu (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_misalign_o,
    output logic [1:0]  lsu_state_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        WAIT_RVALID = 2'd2,
        DONE        = 2'd3
    } state_t;

    state_t      state;
    logic        we_q;
    logic [2:0]  size_q;
    logic [1:0]  off_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] result_q;
    logic        misalign_q;
    logic        abort_q;

    // Request decode from the live core inputs (used in IDLE).
    logic        size_legal;
    logic        misaligned;
    logic        issue_ok;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] word_addr_d;

    assign size_legal  = (lsu_size_i == 3'd0) || (lsu_size_i == 3'd1) ||
                         (lsu_size_i == 3'd2) || (lsu_size_i == 3'd4) ||
                         (lsu_size_i == 3'd5);
    assign word_addr_d = {lsu_addr_i[31:2], 2'b00};

`ifdef MIRISCV_LSU_MISALIGN_EXC_EN
    assign misaligned = ((lsu_size_i[1:0] == 2'b01) && lsu_addr_i[0]) ||
                        ((lsu_size_i[1:0] == 2'b10) && (lsu_addr_i[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign issue_ok = size_legal && !misaligned;

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = lsu_data_i;
        case (lsu_size_i[1:0])
            2'b00: begin
                be_d    = 4'b0001 << lsu_addr_i[1:0];
                wdata_d = {4{lsu_data_i[7:0]}};
            end
            2'b01: begin
                // Half accesses only look at addr[1]; addr[0] is ignored.
                be_d    = 4'b0011 << {lsu_addr_i[1], 1'b0};
                wdata_d = {2{lsu_data_i[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = lsu_data_i;
            end
        endcase
    end

    // Load formatting from the registered size/offset of the transaction.
    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] load_data;

    always_comb begin
        case (size_q[1:0])
            2'b00:   shamt = {off_q, 3'b000};
            2'b01:   shamt = {off_q[1], 4'b0000};
            default: shamt = 5'd0;
        endcase
        shifted = data_rdata_i >> shamt;
        case (size_q)
            3'd0:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'd1:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'd4:    load_data = {24'd0, shifted[7:0]};
            3'd5:    load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            size_q     <= 3'd0;
            off_q      <= 2'd0;
            be_q       <= 4'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            result_q   <= 32'd0;
            misalign_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (lsu_req_i) begin
                        we_q    <= lsu_we_i;
                        size_q  <= lsu_size_i;
                        off_q   <= lsu_addr_i[1:0];
                        be_q    <= be_d;
                        addr_q  <= word_addr_d;
                        wdata_q <= wdata_d;
                        abort_q <= 1'b0;
                        if (!issue_ok) begin
                            // Rejected access: finish without touching memory.
                            result_q   <= 32'd0;
                            misalign_q <= size_legal && misaligned;
                            state      <= DONE;
                        end else if (data_gnt_i) begin
                            state <= WAIT_RVALID;
                        end else begin
                            state <= WAIT_GNT;
                        end
                    end
                end
                WAIT_GNT: begin
                    abort_q <= abort_q || !lsu_req_i;
                    if (data_gnt_i) state <= WAIT_RVALID;
                end
                WAIT_RVALID: begin
                    if (data_rvalid_i) begin
                        // A core that withdrew its request gets no DONE cycle;
                        // the memory response is consumed and dropped.
                        if (abort_q || !lsu_req_i) begin
                            state <= IDLE;
                        end else begin
                            result_q <= we_q ? 32'd0 : load_data;
                            state    <= DONE;
                        end
                    end else begin
                        abort_q <= abort_q || !lsu_req_i;
                    end
                end
                DONE: begin
                    misalign_q <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // IDLE drives the request straight from the core so a zero-wait grant
    // costs no extra cycle; afterwards the registered copies are held.
    always_comb begin
        data_req_o   = 1'b0;
        data_we_o    = we_q;
        data_be_o    = be_q;
        data_addr_o  = addr_q;
        data_wdata_o = wdata_q;
        if (state == IDLE) begin
            data_req_o   = !rst_i && lsu_req_i && issue_ok;
            data_we_o    = lsu_we_i;
            data_be_o    = be_d;
            data_addr_o  = word_addr_d;
            data_wdata_o = wdata_d;
        end else if (state == WAIT_GNT) begin
            data_req_o = !rst_i;
        end
    end

    always_comb begin
        case (state)
            IDLE:        lsu_stall_req_o = lsu_req_i;
            WAIT_GNT:    lsu_stall_req_o = 1'b1;
            WAIT_RVALID: lsu_stall_req_o = 1'b1;
            default:     lsu_stall_req_o = 1'b0;
        endcase
    end

    assign lsu_data_o     = result_q;
    assign lsu_misalign_o = misalign_q;
    assign lsu_state_o    = state;

endmodule
